// File: rtl/mult_simd_accumulator_pkg.sv
// Shared constants for the SIMD product accumulator: lane mode encoding and default widths.
package mult_simd_accumulator_pkg;

    localparam int P_W_DEF  = 18;
    localparam int LO_W_DEF = 8;
    localparam int G_DEF    = 4;

    typedef enum logic {
        MODE_FULL  = 1'b0,
        MODE_SPLIT = 1'b1
    } acc_mode_e;

    function automatic acc_mode_e mode_of(input logic half_1);
        return half_1 ? MODE_SPLIT : MODE_FULL;
    endfunction

endpackage

// File: rtl/mult_simd_accumulator_lane.sv
// One accumulator lane: load or add an extended operand, with carry in/out and
// signed/unsigned overflow detection.
module mult_acc_lane_add #(
    parameter int W = 12
) (
    input  logic [W-1:0] acc_i,
    input  logic [W-1:0] opnd_i,
    input  logic         load_i,
    input  logic         sign_i,
    input  logic         carry_i,
    output logic [W-1:0] sum_o,
    output logic         carry_o,
    output logic         ovf_o
);

    logic [W:0] raw;

    assign raw = {1'b0, acc_i} + {1'b0, opnd_i} + {{W{1'b0}}, carry_i};

    always_comb begin
        sum_o   = raw[W-1:0];
        carry_o = raw[W];
        ovf_o   = 1'b0;
        if (load_i) begin
            sum_o   = opnd_i;
            carry_o = 1'b0;
        end else if (sign_i) begin
            // operands agree in sign but the result does not
            ovf_o = (acc_i[W-1] == opnd_i[W-1]) && (raw[W-1] != acc_i[W-1]);
        end else begin
            ovf_o = raw[W];
        end
    end

endmodule

// File: rtl/mult_simd_accumulator.sv
// Two-stage burst accumulator behind the 9x9 multiplier; full-width or two
// carry-isolated lanes with guard bits and sticky overflow flags.
module mult_simd_accumulator
    import mult_simd_accumulator_pkg::*;
#(
    parameter int  P_W   = P_W_DEF,
    parameter int  LO_W  = LO_W_DEF,
    parameter int  G     = G_DEF,
    localparam int ACC_W = P_W + 2 * G
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_first,
    input  logic             in_last,
    input  logic [P_W-1:0]   C,
    input  logic             half_1,
    input  logic             sign,
    output logic [ACC_W-1:0] acc_out,
    output logic             out_valid,
    output logic             ovf_lo,
    output logic             ovf_hi,
    output logic             mode_err
);

    localparam int LW_LO = LO_W + G;
    localparam int LW_HI = P_W - LO_W + G;

    logic             s1_valid_q, s1_first_q, s1_last_q, s1_half_q, s1_sign_q;
    logic [P_W-1:0]   s1_c_q;

    logic [ACC_W-1:0] acc_q, acc_d;
    acc_mode_e        mode_q, mode_d;
    logic             sign_q, sign_d;
    logic             ovf_lo_q, ovf_lo_d, ovf_hi_q, ovf_hi_d;
    logic             out_valid_q, out_valid_d, mode_err_q, mode_err_d;

    logic             drop, take, split, eff_sign;
    logic [ACC_W-1:0] ext_full;
    logic [LW_LO-1:0] ext_lo, opnd_lo, sum_lo;
    logic [LW_HI-1:0] ext_hi, opnd_hi, sum_hi;
    logic             co_lo, co_hi, ovf_lo_w, ovf_hi_w;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_half_q  <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_c_q     <= '0;
        end else begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_first_q <= in_first;
                s1_last_q  <= in_last;
                s1_half_q  <= half_1;
                s1_sign_q  <= sign;
                s1_c_q     <= C;
            end
        end
    end

    // a continuation beat must match the mode latched by its burst's first beat
    assign drop     = s1_valid_q && !s1_first_q && (mode_of(s1_half_q) != mode_q);
    assign take     = s1_valid_q && !drop;
    assign split    = s1_first_q ? s1_half_q : (mode_q == MODE_SPLIT);
    assign eff_sign = s1_first_q ? s1_sign_q : sign_q;

    assign ext_full = {{(2 * G){eff_sign & s1_c_q[P_W-1]}}, s1_c_q};
    assign ext_lo   = {{G{eff_sign & s1_c_q[LO_W-1]}}, s1_c_q[LO_W-1:0]};
    assign ext_hi   = {{G{eff_sign & s1_c_q[P_W-1]}}, s1_c_q[P_W-1:LO_W]};
    assign opnd_lo  = split ? ext_lo : ext_full[LW_LO-1:0];
    assign opnd_hi  = split ? ext_hi : ext_full[ACC_W-1:LW_LO];

    mult_acc_lane_add #(.W(LW_LO)) u_lane_lo (
        .acc_i   (acc_q[LW_LO-1:0]),
        .opnd_i  (opnd_lo),
        .load_i  (s1_first_q),
        .sign_i  (eff_sign),
        .carry_i (1'b0),
        .sum_o   (sum_lo),
        .carry_o (co_lo),
        .ovf_o   (ovf_lo_w)
    );

    mult_acc_lane_add #(.W(LW_HI)) u_lane_hi (
        .acc_i   (acc_q[ACC_W-1:LW_LO]),
        .opnd_i  (opnd_hi),
        .load_i  (s1_first_q),
        .sign_i  (eff_sign),
        .carry_i (split ? 1'b0 : co_lo),
        .sum_o   (sum_hi),
        .carry_o (co_hi),
        .ovf_o   (ovf_hi_w)
    );

    always_comb begin
        acc_d       = acc_q;
        mode_d      = mode_q;
        sign_d      = sign_q;
        ovf_lo_d    = ovf_lo_q;
        ovf_hi_d    = ovf_hi_q;
        out_valid_d = take && s1_last_q;
        mode_err_d  = drop;
        if (take) begin
            acc_d = {sum_hi, sum_lo};
            if (s1_first_q) begin
                mode_d   = mode_of(s1_half_q);
                sign_d   = s1_sign_q;
                ovf_lo_d = 1'b0;
                ovf_hi_d = 1'b0;
            end else if (split) begin
                ovf_lo_d = ovf_lo_q | ovf_lo_w;
                ovf_hi_d = ovf_hi_q | ovf_hi_w;
            end else begin
                // in full mode the upper lane's add is the MSB of the whole accumulator
                ovf_lo_d = ovf_lo_q | ovf_hi_w;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q       <= '0;
            mode_q      <= MODE_FULL;
            sign_q      <= 1'b0;
            ovf_lo_q    <= 1'b0;
            ovf_hi_q    <= 1'b0;
            out_valid_q <= 1'b0;
            mode_err_q  <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            mode_q      <= mode_d;
            sign_q      <= sign_d;
            ovf_lo_q    <= ovf_lo_d;
            ovf_hi_q    <= ovf_hi_d;
            out_valid_q <= out_valid_d;
            mode_err_q  <= mode_err_d;
        end
    end

    assign acc_out   = acc_q;
    assign out_valid = out_valid_q;
    assign ovf_lo    = ovf_lo_q;
    assign ovf_hi    = ovf_hi_q;
    assign mode_err  = mode_err_q;

    logic unused_co_hi;
    assign unused_co_hi = co_hi;

endmodule

// File: tb/tb_mult_simd_accumulator.sv
// Directed bench for mult_simd_accumulator with hand-computed expected sums.
module tb_mult_simd_accumulator;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0;
    logic        half_1 = 1'b0, sign = 1'b0;
    logic [17:0] C = '0;
    logic [25:0] acc_out;
    logic        out_valid, ovf_lo, ovf_hi, mode_err;

    mult_simd_accumulator dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_first  (in_first),
        .in_last   (in_last),
        .C         (C),
        .half_1    (half_1),
        .sign      (sign),
        .acc_out   (acc_out),
        .out_valid (out_valid),
        .ovf_lo    (ovf_lo),
        .ovf_hi    (ovf_hi),
        .mode_err  (mode_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          ov_cnt = 0, me_cnt = 0, ov_cyc = 0, me_cyc = 0;
    logic [25:0] ov_acc_q[$];
    logic        ov_lo_s = 1'b0, ov_hi_s = 1'b0;

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            ov_cnt++;
            ov_cyc = cyc;
            ov_acc_q.push_back(acc_out);
            ov_lo_s = ovf_lo;
            ov_hi_s = ovf_hi;
        end
        if (mode_err === 1'b1) begin
            me_cnt++;
            me_cyc = cyc;
        end
    end

    int n_chk = 0, n_bad = 0;
    int beat_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic beat(input logic f, input logic l, input logic h, input logic s,
                        input logic [17:0] c);
        @(negedge clk);
        in_valid = 1'b1;
        in_first = f;
        in_last  = l;
        half_1   = h;
        sign     = s;
        C        = c;
        beat_cyc = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_first = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    int ov0, me0, bc;

    initial begin
        idle(2);
        chk("rst_acc", acc_out, 0);
        chk("rst_ov", {out_valid, ovf_lo, ovf_hi, mode_err}, 0);
        @(negedge clk) reset = 1'b0;
        idle(2);

        // full signed: -15 + 30 - 5 = 10
        ov_acc_q.delete(); ov0 = ov_cnt;
        beat(1, 0, 0, 1, 18'h3FFF1);
        beat(0, 0, 0, 1, 18'h0001E);
        beat(0, 1, 0, 1, 18'h3FFFB);
        bc = beat_cyc;
        idle(4);
        chk("full_cnt", ov_cnt - ov0, 1);
        chk("full_acc", ov_acc_q.size() > 0 ? ov_acc_q[0] : 26'h3FFFFFF, 26'h000000A);
        chk("full_lat", ov_cyc - bc, 2);
        chk("full_flags", {ov_lo_s, ov_hi_s}, 0);

        // split signed: lo -6+9=3, hi -10+12=2
        ov_acc_q.delete(); ov0 = ov_cnt;
        beat(1, 0, 1, 1, 18'h3F6FA);
        beat(0, 1, 1, 1, 18'h00C09);
        idle(4);
        chk("split_cnt", ov_cnt - ov0, 1);
        chk("split_lo", acc_out[11:0], 12'h003);
        chk("split_hi", acc_out[25:12], 14'h0002);
        chk("split_flags", {ov_lo_s, ov_hi_s}, 0);

        // split unsigned: 16 x 0xFF fits, 17th overflows the 12-bit low lane
        beat(1, 0, 1, 0, 18'h000FF);
        for (int i = 0; i < 15; i++) beat(0, 0, 1, 0, 18'h000FF);
        idle(4);
        chk("ovf16_lo", acc_out[11:0], 12'hFF0);
        chk("ovf16_flag", ovf_lo, 0);
        beat(0, 0, 1, 0, 18'h000FF);
        idle(4);
        chk("ovf17_acc", acc_out, 26'h00000EF);
        chk("ovf17_flags", {ovf_lo, ovf_hi}, 2'b10);
        ov_acc_q.delete(); ov0 = ov_cnt;
        beat(0, 1, 1, 0, 18'h00001);
        idle(4);
        chk("ovf_sticky_acc", acc_out, 26'h00000F0);
        chk("ovf_sticky", {ov_lo_s, ov_hi_s}, 2'b10);
        beat(1, 1, 1, 0, 18'h00005);
        idle(4);
        chk("ovf_clr_acc", acc_out, 26'h0000005);
        chk("ovf_clr", {ov_lo_s, ov_hi_s}, 0);

        // mode mismatch: dropped beat, then a matching last beat completes
        ov0 = ov_cnt; me0 = me_cnt;
        beat(1, 0, 0, 1, 18'h00010);
        beat(0, 1, 1, 1, 18'h00020);
        bc = beat_cyc;
        idle(4);
        chk("mm_err_cnt", me_cnt - me0, 1);
        chk("mm_err_lat", me_cyc - bc, 2);
        chk("mm_no_ov", ov_cnt - ov0, 0);
        chk("mm_acc", acc_out, 26'h0000010);
        ov_acc_q.delete();
        beat(0, 1, 0, 1, 18'h00003);
        idle(4);
        chk("mm_resume", ov_acc_q.size() > 0 ? ov_acc_q[0] : 26'h3FFFFFF, 26'h0000013);

        // back-to-back bursts and a single-beat burst
        ov_acc_q.delete(); ov0 = ov_cnt;
        beat(1, 0, 0, 0, 18'h00100);
        beat(0, 1, 0, 0, 18'h00200);
        beat(1, 0, 0, 1, 18'h3FFFF);
        beat(0, 1, 0, 1, 18'h00004);
        beat(1, 1, 0, 0, 18'h00007);
        bc = beat_cyc;
        idle(4);
        chk("b2b_cnt", ov_cnt - ov0, 3);
        chk("b2b_a", ov_acc_q.size() > 0 ? ov_acc_q[0] : 26'h3FFFFFF, 26'h0000300);
        chk("b2b_b", ov_acc_q.size() > 1 ? ov_acc_q[1] : 26'h3FFFFFF, 26'h0000003);
        chk("b2b_single", ov_acc_q.size() > 2 ? ov_acc_q[2] : 26'h3FFFFFF, 26'h0000007);
        chk("b2b_lat", ov_cyc - bc, 2);

        // reset the cycle after the last beat flushes the pipeline
        ov0 = ov_cnt;
        beat(1, 0, 0, 0, 18'h00005);
        beat(0, 1, 0, 0, 18'h00006);
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("midrst_acc", acc_out, 0);
        chk("midrst_outs", {out_valid, ovf_lo, ovf_hi, mode_err}, 0);
        idle(2);
        @(negedge clk) reset = 1'b0;
        idle(4);
        chk("midrst_no_ov", ov_cnt - ov0, 0);

        // continuation beat with no prior first: full mode, unsigned onto 0
        ov_acc_q.delete();
        beat(0, 1, 0, 1, 18'h3FFFF);
        idle(4);
        chk("nofirst_acc", ov_acc_q.size() > 0 ? ov_acc_q[0] : 26'h3FFFFFF, 26'h003FFFF);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/mult_simd_accumulator.md
Name: mult_simd_accumulator

Overview:
- Accumulator stage directly downstream of the 9x9 precision-configurable multiplier.
- Takes the 18-bit product bus C each beat and accumulates it over a burst, in one of two modes:
  - Full mode: one 18-bit product.
  - Split mode (HALF_1): two independent lanes, C[7:0] and C[17:8].
- Two-stage pipeline with valid/last framing, per-lane guard bits, carry isolation between lanes, and sticky per-lane overflow flags.
- Output feeds the DSP output register/cascade.

Parameters:
- P_W, 18, product width; must equal multiplier A+B width.
- LO_W, 8, low-lane product width in split mode (C[LO_W-1:0]).
- G, 4, guard bits added to each lane.
- ACC_W, P_W+2*G, accumulator width (derived; do not override).

Ports:
- clk  in  1  clock; all flops rising-edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  C carries a product this cycle.
- in_first  in  1  beat starts a new accumulation (load, not add); mode and sign are sampled here.
- in_last  in  1  beat ends the accumulation.
- C  in  P_W  product from multiplier.
- half_1  in  1  split mode select (same signal driven to the multiplier HALF_1).
- sign  in  1  products are signed (A_sign|B_sign of the multiplier).
- acc_out  out  ACC_W  accumulated result.
  - Full mode: [ACC_W-1:0].
  - Split mode: low lane [LO_W+G-1:0], high lane [ACC_W-1:LO_W+G].
- out_valid  out  1  one-cycle pulse; acc_out is final.
- ovf_lo  out  1  sticky overflow, low lane (or the whole accumulator in full mode).
- ovf_hi  out  1  sticky overflow, high lane (always 0 in full mode).
- mode_err  out  1  one-cycle pulse; a beat was dropped due to a mode mismatch.

Behaviour:
- Reset (async assert, sync release): all registers 0.
  - acc_out=0, out_valid=0, ovf_lo=0, ovf_hi=0, mode_err=0.
  - Internal mode register=full, stage-1 valid=0.
- Stage 1 (cycle t+1 after accepted beat at t): register C, first, last, half_1, sign, valid.
- Stage 2 (cycle t+2): update accumulator; out_valid=1 at t+2 iff the beat had last=1.
  - Latency from in_valid to out_valid is 2 cycles.
  - Throughput is one beat per cycle; there is no backpressure.
- Mode/sign latch: the mode and sign registers load in stage 2 only on a first beat.
  - A non-first beat whose half_1 differs from the latched mode is dropped.
  - The dropped beat leaves accumulator and flags unchanged and pulses mode_err at t+2.
  - If that beat also had last=1, out_valid is not asserted.
- Extension: each lane is sign-extended (if sign) or zero-extended to its lane width.
  - Full: C (P_W bits) extends to ACC_W.
  - Split low: C[LO_W-1:0] extends to LO_W+G.
  - Split high: C[P_W-1:LO_W] extends to P_W-LO_W+G.
- Accumulate: on a first beat, acc=extended product; otherwise acc=acc+extended product.
  - Split mode forces the carry from low lane into high lane to 0; each lane wraps modulo 2^lane width.
  - Full mode has a single ACC_W-bit add with wrap.
- Overflow is set on signed overflow (sign=1) or unsigned carry-out (sign=0) of the lane add.
  - Flags are sticky until the next first beat, which reloads them to 0.
  - A first beat cannot overflow.
- Beat with in_valid=0: the in_first, in_last, half_1 and sign inputs are ignored.
- Non-first beat with no prior first since reset: accumulates onto 0 in full mode, unsigned.
- A beat with first=1 and last=1 is a single-beat burst: acc=extended product, out_valid pulses.
- acc_out holds its value between bursts and shows running partial sums during a burst.
  - Consumers sample acc_out only on out_valid.
- Reset asserted mid-burst: the pipeline is flushed immediately and the beats already in flight produce no out_valid.

Decomposition:
- Shared package: mode encoding constants (MODE_FULL=0, MODE_SPLIT=1), default widths P_W=18, LO_W=8, G=4.
- One sub-module, mult_acc_lane_add: parameterised width W.
  - Inputs: acc, extended operand, load, sign, carry_in.
  - Outputs: sum, carry_out, ovf.
  - Instantiated twice (low and high lane); full mode chains carry_out(low) into carry_in(high).

Test Plan:
- Full signed, G=4:
  - Stimulus: beats C=0x3FFF1 (-15) first, 0x0001E (30), 0x3FFFB (-5) last.
  - Response: acc_out=26'h000000A (10), out_valid exactly 2 cycles after the last beat, no flags.
- Split signed:
  - Stimulus: beats (hi,lo)=(10'h3F6 -10, 8'hFA -6) first, then (10'h00C 12, 8'h09 9) last.
  - Response: low lane=12'h003, high lane=14'h0002.
  - No carry leaks between lanes; in particular the low-lane wrap 0xFA+0x09 leaves the high lane unaffected.
- Unsigned overflow, split:
  - Stimulus: 17 beats with lo=8'hFF, sign=0.
  - Response: low lane wraps past 12 bits; ovf_lo=1 and sticky, ovf_hi=0.
  - A subsequent first beat clears ovf_lo.
- Mode mismatch:
  - Stimulus: first beat with half_1=0, then a beat with half_1=1 and last=1.
  - Response: mode_err pulse, no out_valid, acc_out unchanged.
- Back-to-back bursts:
  - Stimulus: last of burst A immediately followed by first of burst B.
  - Response: out_valid on consecutive-burst boundaries with correct independent sums; single-beat burst (first=last=1, C=0x00007) gives acc_out=7.
- Reset mid-burst:
  - Stimulus: assert reset the cycle after the last beat.
  - Response: out_valid never pulses; all outputs 0 during reset.
